cpu_axi_bridge: RTL and testbench
=================================

CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

Interface
REQ-001 Parameters: none; all AXI constant fields are fixed in Function.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 The block SHALL provide the following ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- inst_sram_{req,wr,size[1:0],addr[31:0],wstrb[3:0],wdata[31:0]}  input  -  instruction-side SRAM-like request.
- inst_sram_{addr_ok,data_ok,rdata[31:0]}  output  -  instruction-side accept, return and read data.
- data_sram_{req,wr,size[1:0],addr[31:0],wstrb[3:0],wdata[31:0]}  input  -  data-side SRAM-like request.
- data_sram_{addr_ok,data_ok,rdata[31:0]}  output  -  data-side accept, return and read data.
- arid[3:0],araddr[31:0],arlen[7:0],arsize[2:0],arburst[1:0],arlock[1:0],arcache[3:0],arprot[2:0],arvalid  output  -  AXI AR channel.
- arready  input  1  AXI AR channel.
- rid[3:0],rdata[31:0],rresp[1:0],rlast,rvalid  input  -  AXI R channel.
- rready  output  1  AXI R channel.
- awid,awaddr,awlen,awsize,awburst,awlock,awcache,awprot,awvalid  output  -  AXI AW channel, widths as AR.
- awready  input  1  AXI AW channel.
- wid[3:0],wdata[31:0],wstrb[3:0],wlast,wvalid  output  -  AXI W channel.
- wready  input  1  AXI W channel.
- bid[3:0],bresp[1:0],bvalid  input  -  AXI B channel.
- bready  output  1  AXI B channel.

Function
REQ-004 Constant AXI fields SHALL be driven as follows:
- arlen = awlen = 0.
- arburst = awburst = 2'b01.
- lock = cache = prot = 0.
- awid = wid = 1.
- wlast = 1.
REQ-005 Size encoding SHALL be arsize/awsize = {1'b0, size}.
REQ-006 Read FSM states SHALL be AR_IDLE and AR_BUSY; in AR_IDLE the block SHALL latch one eligible read, pulse the matching addr_ok for that cycle only, and move to AR_BUSY.
REQ-007 In AR_BUSY, arvalid SHALL be 1 with araddr/arsize/arid stable; on arvalid&&arready the FSM SHALL return to AR_IDLE; no addr_ok SHALL be raised in AR_BUSY.
REQ-008 Read id SHALL be 0 for instruction reads and 1 for data reads.
REQ-009 Eligibility:
- Instruction read: inst_sram_req=1 and inst_rd_pend=0; inst_sram_wr is ignored and always treated as a read.
- Data read: data_sram_req=1, data_sram_wr=0, data_rd_pend=0, write FSM in W_IDLE.
REQ-010 When both reads are eligible, the data read SHALL win; the instruction read SHALL wait with no addr_ok.
REQ-011 rready SHALL be constant 1 after reset.
REQ-012 Read return routing: on rvalid, rid[0]=0 SHALL pulse inst_sram_data_ok with inst_sram_rdata=rdata and clear inst_rd_pend; rid[0]=1 SHALL do the same on the data side and clear data_rd_pend.
REQ-013 A *_rd_pend flag SHALL set on the addr_ok cycle; if set and clear occur in the same cycle, set SHALL win.
REQ-014 Data_ok SHALL be combinational from rvalid/bvalid, with zero added latency.
REQ-015 Write FSM states SHALL be W_IDLE, W_SEND and W_RESP.
REQ-016 In W_IDLE, when data_sram_req=1, data_sram_wr=1 and data_rd_pend=0, the block SHALL:
- pulse data_sram_addr_ok;
- latch addr, size, wstrb and wdata;
- move to W_SEND.
REQ-017 In W_SEND, awvalid and wvalid SHALL start at 1 and each SHALL drop independently on its own handshake; when both handshakes are complete the FSM SHALL enter W_RESP.
REQ-018 In W_RESP, bready SHALL be 1; on bvalid the block SHALL pulse data_sram_data_ok (rdata don't-care) and return to W_IDLE.
REQ-019 Ordering: the data side SHALL have at most one outstanding transaction, so data_ok order equals addr_ok order; the instruction side SHALL have at most one outstanding read.
REQ-020 inst_sram_data_ok and data_sram_data_ok MAY assert in the same cycle; each SHALL be independent.
REQ-021 rresp and bresp SHALL be ignored.
REQ-022 Instruction reads are NOT ordered against data writes; software handles self-modifying code.

Reset
REQ-023 On reset assertion, asynchronously:
- FSMs go to AR_IDLE/W_IDLE;
- pend flags = 0;
- arvalid/awvalid/wvalid/bready = 0;
- all addr_ok/data_ok = 0;
- latched address/data registers = 0.
REQ-024 rready SHALL be 0 during reset and 1 from the first cycle after release.
REQ-025 Reset mid-transaction SHALL abandon it with no data_ok; the AXI slave is reset with the block.

Verification
REQ-026 Inst fetch: inst req addr=0x1C000000, arready=1, R returns rid=0, rdata=0x02800C0C two cycles later -> one addr_ok pulse, arid=0, araddr=0x1C000000, arsize=2, inst_sram_data_ok=1 with rdata=0x02800C0C.
REQ-027 Arbitration: inst read and data read (addr=0x1C008000) requested the same cycle -> data_sram_addr_ok=1, inst_sram_addr_ok=0; inst accepted only after AR returns to AR_IDLE.
REQ-028 Store: data write addr=0x1C008004, size=0, wstrb=4'b0010, wdata=0x0000AB00; awready 1 cycle late, wready immediate, bvalid 3 cycles later -> awsize=0, wstrb=0010, single data_ok on bvalid.
REQ-029 Load behind store: data read requested while write FSM is in W_RESP -> no addr_ok until W_IDLE; afterwards arid=1.
REQ-030 Simultaneous return: rvalid rid=0 and bvalid in the same cycle -> both data_ok pulse in that cycle.
REQ-031 Reset while arvalid=1 -> arvalid=0 immediately (asynchronous); no data_ok; after release, the next request is accepted normally.

Source files
------------

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: joins an instruction-side and a data-side SRAM-like port
// onto one AXI master. Reads share the AR channel, and a data read beats an
// instruction read. Only the data port can write. Each side allows one
// outstanding transaction, and R returns are routed back by rid[0].
module cpu_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  // instruction-side SRAM-like port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data-side SRAM-like port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AXI AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI AW
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI W
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI B
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  ar_state_t   ar_state, ar_state_n;
  w_state_t    w_state, w_state_n;
  logic        inst_rd_pend, data_rd_pend;
  logic        ar_id;
  logic [31:0] ar_addr;
  logic [1:0]  ar_size;
  logic        aw_valid_q, aw_valid_n, w_valid_q, w_valid_n;
  logic [31:0] aw_addr, w_data;
  logic [1:0]  aw_size;
  logic [3:0]  w_strb;
  logic        data_rd_go, inst_rd_go, wr_go;
  logic        inst_ret, data_ret;

  // The instruction port has no writes. Responses carry no status that this
  // bridge acts on. These inputs are folded into one sink.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rresp, rlast, rid[3:1], bid, bresp};

  // Request acceptance. addr_ok stays low while reset is asserted.
  assign data_rd_go = !reset && (ar_state == AR_IDLE) && data_sram_req && !data_sram_wr
                      && !data_rd_pend && (w_state == W_IDLE);
  assign inst_rd_go = !reset && (ar_state == AR_IDLE) && inst_sram_req && !inst_rd_pend
                      && !data_rd_go;
  assign wr_go      = !reset && (w_state == W_IDLE) && data_sram_req && data_sram_wr
                      && !data_rd_pend;

  // Response routing is combinational, so no latency is added.
  assign inst_ret = rvalid && rready && !rid[0];
  assign data_ret = rvalid && rready &&  rid[0];

  assign inst_sram_addr_ok = inst_rd_go;
  assign data_sram_addr_ok = data_rd_go || wr_go;
  assign inst_sram_data_ok = inst_ret;
  assign data_sram_data_ok = data_ret || (bvalid && (w_state == W_RESP));
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // Fixed AXI fields: single beat, INCR burst, no lock/cache/prot.
  assign arid    = {3'b000, ar_id};
  assign araddr  = ar_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, ar_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (ar_state == AR_BUSY);

  assign awid    = 4'd1;
  assign awaddr  = aw_addr;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, aw_size};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = aw_valid_q;

  assign wid     = 4'd1;
  assign wdata   = w_data;
  assign wstrb   = w_strb;
  assign wlast   = 1'b1;
  assign wvalid  = w_valid_q;
  assign bready  = (w_state == W_RESP);

  // rready is held low during reset and rises on the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    if (reset) rready <= 1'b0;
    else       rready <= 1'b1;
  end

  // Read FSM next state: a read leaves AR_IDLE when accepted, and returns once AR handshakes.
  always_comb begin
    // NOTE: assign the default first, so no path through the case leaves it unassigned (no latch).
    ar_state_n = ar_state;
    case (ar_state)
      AR_IDLE: if (data_rd_go || inst_rd_go) ar_state_n = AR_BUSY;
      AR_BUSY: if (arready)                  ar_state_n = AR_IDLE;
      default:                               ar_state_n = AR_IDLE;
    endcase
  end

  // Read FSM state register and latched AR fields (stable while AR_BUSY).
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the latched address and data registers are reset too, so the AXI fields are never X.
    if (reset) begin
      ar_state <= AR_IDLE;
      ar_id    <= 1'b0;
      ar_addr  <= 32'd0;
      ar_size  <= 2'd0;
    end else begin
      ar_state <= ar_state_n;
      if (data_rd_go) begin
        ar_id   <= 1'b1;
        ar_addr <= data_sram_addr;
        ar_size <= data_sram_size;
      end else if (inst_rd_go) begin
        ar_id   <= 1'b0;
        ar_addr <= inst_sram_addr;
        ar_size <= inst_sram_size;
      end
    end
  end

  // Outstanding-read flags. When set and clear fall in the same cycle, set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_rd_pend <= 1'b0;
      data_rd_pend <= 1'b0;
    end else begin
      if (inst_rd_go)    inst_rd_pend <= 1'b1;
      else if (inst_ret) inst_rd_pend <= 1'b0;
      if (data_rd_go)    data_rd_pend <= 1'b1;
      else if (data_ret) data_rd_pend <= 1'b0;
    end
  end

  // Write FSM next state. AW and W each drop on their own handshake.
  always_comb begin
    w_state_n  = w_state;
    aw_valid_n = aw_valid_q;
    w_valid_n  = w_valid_q;
    case (w_state)
      W_IDLE: if (wr_go) begin
        w_state_n  = W_SEND;
        aw_valid_n = 1'b1;
        w_valid_n  = 1'b1;
      end
      W_SEND: begin
        if (aw_valid_q && awready) aw_valid_n = 1'b0;
        if (w_valid_q && wready)   w_valid_n  = 1'b0;
        if (!aw_valid_n && !w_valid_n) w_state_n = W_RESP;
      end
      W_RESP: if (bvalid) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Write FSM state register, valid flags and latched write payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state    <= W_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_addr    <= 32'd0;
      aw_size    <= 2'd0;
      w_strb     <= 4'd0;
      w_data     <= 32'd0;
    end else begin
      w_state    <= w_state_n;
      aw_valid_q <= aw_valid_n;
      w_valid_q  <= w_valid_n;
      if (wr_go) begin
        aw_addr <= data_sram_addr;
        aw_size <= data_sram_size;
        w_strb  <= data_sram_wstrb;
        w_data  <= data_sram_wdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed testbench for cpu_axi_bridge. Inputs change 1 ns after each rising
// edge. Outputs are sampled mid-cycle.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle (sample point).
  task automatic settle();
    #4;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000000; inst_sram_size = 2'd2;
    cyc(); cyc(); settle();
    n_cmp++; if (inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL rst_inst_addr_ok: got %b want 0", inst_sram_addr_ok); end
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b000) begin n_bad++; $display("FAIL rst_aw_w_b: got %b want 000", {awvalid, wvalid, bready}); end
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL rst_rready: got %b want 0", rready); end
    n_cmp++; if (araddr !== 32'd0) begin n_bad++; $display("FAIL rst_araddr: got %h want 0", araddr); end
    inst_sram_req = 1'b0;
    cyc(); reset = 1'b0;
    cyc(); settle();
    n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL post_rst_rready: got %b want 1", rready); end
    n_cmp++; if ({arlen, awlen, arburst, awburst} !== {8'd0, 8'd0, 2'b01, 2'b01}) begin n_bad++;
      $display("FAIL const_len_burst: got %h %h %b %b want 0 0 01 01", arlen, awlen, arburst, awburst); end
    n_cmp++; if ({arlock, arcache, arprot, awlock, awcache, awprot} !== 18'd0) begin n_bad++;
      $display("FAIL const_lock_cache_prot: got %h want 0", {arlock, arcache, arprot, awlock, awcache, awprot}); end
    n_cmp++; if ({awid, wid, wlast} !== {4'd1, 4'd1, 1'b1}) begin n_bad++; $display("FAIL const_ids_wlast: got %h %h %b want 1 1 1", awid, wid, wlast); end
  endtask

  task automatic test_inst_fetch();
    cyc(); inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1C000000; inst_sram_size = 2'd2; settle();
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL fetch_addr_ok: got %b want 1", inst_sram_addr_ok); end
    n_cmp++; if (data_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_data_addr_ok: got %b want 0", data_sram_addr_ok); end
    cyc(); arready = 1'b1; settle();
    n_cmp++; if (arvalid !== 1'b1) begin n_bad++; $display("FAIL fetch_arvalid: got %b want 1", arvalid); end
    n_cmp++; if ({arid, araddr, arsize} !== {4'd0, 32'h1C000000, 3'd2}) begin n_bad++;
      $display("FAIL fetch_ar_fields: got id=%h addr=%h size=%h want 0 1c000000 2", arid, araddr, arsize); end
    n_cmp++; if (inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_busy_addr_ok: got %b want 0", inst_sram_addr_ok); end
    cyc(); arready = 1'b0; settle();
    n_cmp++; if ({arvalid, inst_sram_addr_ok} !== 2'b00) begin n_bad++; $display("FAIL fetch_pend_block: got arvalid/addr_ok=%b want 00", {arvalid, inst_sram_addr_ok}); end
    cyc(); inst_sram_req = 1'b0; inst_sram_wr = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800C0C; settle();
    n_cmp++; if (inst_sram_data_ok !== 1'b1) begin n_bad++; $display("FAIL fetch_data_ok: got %b want 1", inst_sram_data_ok); end
    n_cmp++; if (inst_sram_rdata !== 32'h02800C0C) begin n_bad++; $display("FAIL fetch_rdata: got %h want 02800c0c", inst_sram_rdata); end
    n_cmp++; if (data_sram_data_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_data_side_quiet: got %b want 0", data_sram_data_ok); end
    cyc(); rvalid = 1'b0; settle();
    n_cmp++; if (inst_sram_data_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_data_ok_drop: got %b want 0", inst_sram_data_ok); end
  endtask

  task automatic test_arbitration();
    cyc();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000040; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1C008000; data_sram_size = 2'd2;
    settle();
    n_cmp++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin n_bad++; $display("FAIL arb_addr_ok: got data/inst=%b want 10", {data_sram_addr_ok, inst_sram_addr_ok}); end
    cyc(); data_sram_req = 1'b0; arready = 1'b0; settle();
    n_cmp++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h1C008000}) begin n_bad++;
      $display("FAIL arb_data_ar: got v=%b id=%h addr=%h want 1 1 1c008000", arvalid, arid, araddr); end
    n_cmp++; if (inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL arb_inst_wait1: got %b want 0", inst_sram_addr_ok); end
    cyc(); arready = 1'b1; settle();
    n_cmp++; if (inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL arb_inst_wait2: got %b want 0", inst_sram_addr_ok); end
    cyc(); arready = 1'b0; settle();
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL arb_inst_accept: got %b want 1", inst_sram_addr_ok); end
    cyc(); inst_sram_req = 1'b0; arready = 1'b1; settle();
    n_cmp++; if ({arid, araddr} !== {4'd0, 32'h1C000040}) begin n_bad++; $display("FAIL arb_inst_ar: got id=%h addr=%h want 0 1c000040", arid, araddr); end
    cyc(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h11112222; settle();
    n_cmp++; if ({data_sram_data_ok, inst_sram_data_ok, data_sram_rdata} !== {2'b10, 32'h11112222}) begin n_bad++;
      $display("FAIL arb_data_ret: got ok=%b%b rdata=%h want 10 11112222", data_sram_data_ok, inst_sram_data_ok, data_sram_rdata); end
    cyc(); rid = 4'd0; rdata = 32'h33334444; settle();
    n_cmp++; if ({data_sram_data_ok, inst_sram_data_ok, inst_sram_rdata} !== {2'b01, 32'h33334444}) begin n_bad++;
      $display("FAIL arb_inst_ret: got ok=%b%b rdata=%h want 01 33334444", data_sram_data_ok, inst_sram_data_ok, inst_sram_rdata); end
    cyc(); rvalid = 1'b0;
  endtask

  task automatic test_store();
    cyc();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1C008004; data_sram_size = 2'd0;
    data_sram_wstrb = 4'b0010; data_sram_wdata = 32'h0000AB00;
    settle();
    n_cmp++; if (data_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL store_addr_ok: got %b want 1", data_sram_addr_ok); end
    cyc(); data_sram_req = 1'b0; data_sram_wr = 1'b0; awready = 1'b0; wready = 1'b1; settle();
    n_cmp++; if ({awvalid, wvalid} !== 2'b11) begin n_bad++; $display("FAIL store_valids: got aw/w=%b want 11", {awvalid, wvalid}); end
    n_cmp++; if ({awaddr, awsize, wstrb, wdata} !== {32'h1C008004, 3'd0, 4'b0010, 32'h0000AB00}) begin n_bad++;
      $display("FAIL store_fields: got addr=%h size=%h strb=%b data=%h want 1c008004 0 0010 0000ab00", awaddr, awsize, wstrb, wdata); end
    cyc(); awready = 1'b1; wready = 1'b0; settle();
    n_cmp++; if ({awvalid, wvalid} !== 2'b10) begin n_bad++; $display("FAIL store_w_dropped: got aw/w=%b want 10", {awvalid, wvalid}); end
    cyc(); awready = 1'b0; settle();
    n_cmp++; if ({awvalid, bready, data_sram_data_ok} !== 3'b010) begin n_bad++; $display("FAIL store_resp_wait1: got aw/b/ok=%b want 010", {awvalid, bready, data_sram_data_ok}); end
    cyc(); settle();
    n_cmp++; if (data_sram_data_ok !== 1'b0) begin n_bad++; $display("FAIL store_resp_wait2: got %b want 0", data_sram_data_ok); end
    cyc(); bvalid = 1'b1; settle();
    n_cmp++; if (data_sram_data_ok !== 1'b1) begin n_bad++; $display("FAIL store_data_ok: got %b want 1", data_sram_data_ok); end
    cyc(); bvalid = 1'b0; settle();
    n_cmp++; if ({data_sram_data_ok, bready} !== 2'b00) begin n_bad++; $display("FAIL store_done: got ok/bready=%b want 00", {data_sram_data_ok, bready}); end
  endtask

  task automatic test_load_behind_store();
    cyc();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1C008008; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'h12345678;
    cyc(); data_sram_req = 1'b0; data_sram_wr = 1'b0; awready = 1'b1; wready = 1'b1;
    cyc(); awready = 1'b0; wready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1C00800C; data_sram_size = 2'd2;
    settle();
    n_cmp++; if ({data_sram_addr_ok, bready} !== 2'b01) begin n_bad++; $display("FAIL lbs_blocked: got addr_ok/bready=%b want 01", {data_sram_addr_ok, bready}); end
    cyc(); bvalid = 1'b1; settle();
    n_cmp++; if ({data_sram_addr_ok, data_sram_data_ok} !== 2'b01) begin n_bad++; $display("FAIL lbs_bresp: got addr_ok/data_ok=%b want 01", {data_sram_addr_ok, data_sram_data_ok}); end
    cyc(); bvalid = 1'b0; settle();
    n_cmp++; if (data_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL lbs_accept: got %b want 1", data_sram_addr_ok); end
    cyc(); data_sram_req = 1'b0; arready = 1'b1; settle();
    n_cmp++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h1C00800C}) begin n_bad++;
      $display("FAIL lbs_ar: got v=%b id=%h addr=%h want 1 1 1c00800c", arvalid, arid, araddr); end
    cyc(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'hCAFEF00D; settle();
    n_cmp++; if ({data_sram_data_ok, data_sram_rdata} !== {1'b1, 32'hCAFEF00D}) begin n_bad++;
      $display("FAIL lbs_ret: got ok=%b rdata=%h want 1 cafef00d", data_sram_data_ok, data_sram_rdata); end
    cyc(); rvalid = 1'b0;
  endtask

  task automatic test_simultaneous_return();
    cyc();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000100; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1C008010; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'h5;
    settle();
    n_cmp++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b11) begin n_bad++; $display("FAIL sim_addr_ok: got inst/data=%b want 11", {inst_sram_addr_ok, data_sram_addr_ok}); end
    cyc(); inst_sram_req = 1'b0; data_sram_req = 1'b0; data_sram_wr = 1'b0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    cyc(); arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0A0B0C0D; bvalid = 1'b1; settle();
    n_cmp++; if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b11, 32'h0A0B0C0D}) begin n_bad++;
      $display("FAIL sim_both_ok: got inst/data=%b%b rdata=%h want 11 0a0b0c0d", inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata); end
    cyc(); rvalid = 1'b0; bvalid = 1'b0; settle();
    n_cmp++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin n_bad++; $display("FAIL sim_drop: got %b want 00", {inst_sram_data_ok, data_sram_data_ok}); end
  endtask

  task automatic test_reset_mid();
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000200; inst_sram_size = 2'd2;
    cyc(); inst_sram_req = 1'b0; arready = 1'b0; settle();
    n_cmp++; if (arvalid !== 1'b1) begin n_bad++; $display("FAIL rmid_arvalid_before: got %b want 1", arvalid); end
    #1; reset = 1'b1; rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEADBEEF; #1;
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_arvalid_async: got %b want 0", arvalid); end
    n_cmp++; if ({inst_sram_data_ok, data_sram_data_ok, rready} !== 3'b000) begin n_bad++;
      $display("FAIL rmid_no_data_ok: got inst/data/rready=%b want 000", {inst_sram_data_ok, data_sram_data_ok, rready}); end
    rvalid = 1'b0;
    cyc(); cyc(); reset = 1'b0;
    cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000300; settle();
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL rmid_reaccept: got %b want 1", inst_sram_addr_ok); end
    cyc(); inst_sram_req = 1'b0; arready = 1'b1; settle();
    n_cmp++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1C000300}) begin n_bad++;
      $display("FAIL rmid_ar: got v=%b id=%h addr=%h want 1 0 1c000300", arvalid, arid, araddr); end
    cyc(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h00000077; settle();
    n_cmp++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h00000077}) begin n_bad++;
      $display("FAIL rmid_ret: got ok=%b rdata=%h want 1 00000077", inst_sram_data_ok, inst_sram_rdata); end
    cyc(); rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = 32'd0;
    inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0; data_sram_addr = 32'd0;
    data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;

    test_reset();
    test_inst_fetch();
    test_arbitration();
    test_store();
    test_load_behind_store();
    test_simultaneous_return();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
